// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the tdest-routed AXIS switch.
//   dest_bits()       : width of a destination index for a given number of
//                       destinations (never less than one bit).
//   beat_width()      : packed width of one stored beat {data, user, last, dest}.
//   extract_state_e   : header / body state of the destination extractor.
//   axis_beat_t       : stored beat record at the switch's default widths.
//                       Blocks with other widths declare a local struct with
//                       the same field order; beat_width() sizes its storage.
// -----------------------------------------------------------------------------
package axis_pkg;

  localparam int AXIS_DATA_W_DEF = 8;
  localparam int AXIS_USER_W_DEF = 1;
  localparam int AXIS_DEST_W_DEF = 1;

  // A single destination still needs one bit so the tdest port exists.
  function automatic int dest_bits(input int n);
    int w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

  function automatic int beat_width(input int data_w, input int user_w, input int dest_w);
    return data_w + user_w + 1 + dest_w;
  endfunction

  typedef enum logic [0:0] {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } extract_state_e;

  typedef struct packed {
    logic [AXIS_DATA_W_DEF-1:0] data;
    logic [AXIS_USER_W_DEF-1:0] user;
    logic                       last;
    logic [AXIS_DEST_W_DEF-1:0] dest;
  } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry FIFO-style skid buffer with a registered input ready. The output
// is always taken from the oldest entry, so it holds still while stalled.
// Ports:
//   clk, aresetn              : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o   : write handshake (ready is a flop)
//   in_data_i                 : payload written on accept
//   out_valid_o / out_ready_i : read handshake
//   out_data_o                : oldest stored payload
// -----------------------------------------------------------------------------
module axis_skid_buffer
  import axis_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             ready_q, ready_d;
  logic             push_s, pop_s;

  // Occupancy and pointer bookkeeping for this cycle's push/pop.
  always_comb begin
    push_s   = in_valid_i & ready_q;
    pop_s    = (count_q != 2'd0) & out_ready_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case ({push_s, pop_s})
      2'b10: begin
        count_d  = count_q + 2'd1;
        wr_ptr_d = ~wr_ptr_q;
      end
      2'b01: begin
        count_d  = count_q - 2'd1;
        rd_ptr_d = ~rd_ptr_q;
      end
      2'b11: begin
        wr_ptr_d = ~wr_ptr_q;
        rd_ptr_d = ~rd_ptr_q;
      end
      default: begin
        count_d = count_q;
      end
    endcase
    // Ready looks only at post-transfer occupancy, so out_ready_i never
    // reaches in_ready_o within a cycle.
    ready_d = (count_d != 2'd2);
  end

  // Storage, pointers, occupancy and the ready flop.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= in_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/axis_dest_extract.sv
// -----------------------------------------------------------------------------
// axis_dest_extract
// Pulls a destination index out of a header byte on the first beat of each
// packet and re-emits the stream with that index on tdest for every beat.
// Optionally consumes the header beat instead of forwarding it.
// Ports:
//   clk, aresetn                     : clock, asynchronous active-low reset
//   axis_i_t{valid,ready,data,user,last} : slave stream
//   axis_o_t{valid,ready,data,user,last,dest} : master stream (registered)
//   bad_dest                         : one-cycle pulse after a header whose
//                                      byte is >= NUM_DESTS
// -----------------------------------------------------------------------------
module axis_dest_extract
  import axis_pkg::*;
#(
  parameter int  AXIS_BYTES     = 1,
  parameter int  AXIS_USER_BITS = 1,
  parameter int  NUM_DESTS      = 2,
  parameter int  DEST_BYTE      = 0,
  parameter int  DEFAULT_DEST   = 0,
  parameter bit  DROP_HEADER    = 1'b0,
  localparam int DEST_BITS      = dest_bits(NUM_DESTS)
) (
  input  logic                      clk,
  input  logic                      aresetn,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  output logic [DEST_BITS-1:0]      axis_o_tdest,
  output logic                      bad_dest
);

  localparam int DATA_W = 8 * AXIS_BYTES;

  typedef struct packed {
    logic [DATA_W-1:0]         data;
    logic [AXIS_USER_BITS-1:0] user;
    logic                      last;
    logic [DEST_BITS-1:0]      dest;
  } beat_t;

  localparam int BEAT_W = beat_width(DATA_W, AXIS_USER_BITS, DEST_BITS);

  extract_state_e       state_q, state_d;
  logic [DEST_BITS-1:0] cur_dest_q, cur_dest_d;
  logic                 bad_dest_q, bad_dest_d;

  logic                 accept_s;
  logic [7:0]           raw_dest_s;
  logic                 hdr_bad_s;
  logic [DEST_BITS-1:0] hdr_dest_s;
  logic                 wr_valid_s;
  beat_t                wr_beat_s;
  beat_t                rd_beat_s;
  logic                 buf_valid_s;

  assign accept_s = axis_i_tvalid & axis_i_tready;

  // Header decode: range check uses the whole byte, not the truncated index.
  always_comb begin
    raw_dest_s = axis_i_tdata[8*DEST_BYTE +: 8];
    if (int'({24'd0, raw_dest_s}) >= NUM_DESTS) begin
      hdr_bad_s  = 1'b1;
      hdr_dest_s = DEST_BITS'(DEFAULT_DEST);
    end else begin
      hdr_bad_s  = 1'b0;
      hdr_dest_s = DEST_BITS'(raw_dest_s);
    end
  end

  // Header/body FSM: tags each accepted beat and decides whether it is stored.
  always_comb begin
    state_d        = state_q;
    cur_dest_d     = cur_dest_q;
    bad_dest_d     = 1'b0;
    wr_valid_s     = 1'b0;
    wr_beat_s.data = axis_i_tdata;
    wr_beat_s.user = axis_i_tuser;
    wr_beat_s.last = axis_i_tlast;
    wr_beat_s.dest = cur_dest_q;
    case (state_q)
      ST_HDR: begin
        // The header beat is tagged with its own freshly decoded destination.
        wr_beat_s.dest = hdr_dest_s;
        if (accept_s) begin
          cur_dest_d = hdr_dest_s;
          bad_dest_d = hdr_bad_s;
          wr_valid_s = ~DROP_HEADER;
          if (axis_i_tlast) begin
            state_d = ST_HDR;
          end else begin
            state_d = ST_BODY;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_BODY: begin
        if (accept_s) begin
          wr_valid_s = 1'b1;
          if (axis_i_tlast) begin
            state_d = ST_HDR;
          end else begin
            state_d = ST_BODY;
          end
        end else begin
          state_d = ST_BODY;
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  // FSM state, latched destination and the bad_dest pulse flop.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_HDR;
      cur_dest_q <= '0;
      bad_dest_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dest_q <= cur_dest_d;
      bad_dest_q <= bad_dest_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH(BEAT_W)
  ) u_skid (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_valid_i (wr_valid_s),
    .in_ready_o (axis_i_tready),
    .in_data_i  (wr_beat_s),
    .out_valid_o(buf_valid_s),
    .out_ready_i(axis_o_tready),
    .out_data_o (rd_beat_s)
  );

  assign axis_o_tvalid = buf_valid_s;
  assign axis_o_tdata  = rd_beat_s.data;
  assign axis_o_tuser  = rd_beat_s.user;
  assign axis_o_tlast  = rd_beat_s.last;
  assign axis_o_tdest  = rd_beat_s.dest;
  assign bad_dest      = bad_dest_q;

endmodule

// File: tb/tb_axis_dest_extract.sv
// -----------------------------------------------------------------------------
// tb_axis_dest_extract
// Two DUT instances:
//   dut0: 2 data bytes, header in byte 1, 3 destinations, default 0, forwards
//         the header beat.
//   dut1: 2 data bytes, header in byte 0, 4 destinations, default 2, drops the
//         header beat.
// A per-instance packet model (queue of expected beats) checks ready, valid,
// payload and bad_dest every cycle; directed tables and sequences cover the
// named corner cases, then a random phase runs both streams concurrently.
// -----------------------------------------------------------------------------
module tb_axis_dest_extract;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  user;
    logic        last;
    logic [1:0]  dest;
  } beat_t;

  typedef struct {
    int          d;
    logic [15:0] data;
    logic [1:0]  user;
    logic        last;
    bit          out;
    logic [1:0]  dest;
  } vec_t;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        iv [2];
  logic        il [2];
  logic        ir [2];
  logic        ov [2];
  logic        ol [2];
  logic        ordy [2];
  logic        bad [2];
  logic [15:0] id [2];
  logic [15:0] od [2];
  logic [1:0]  iu [2];
  logic [1:0]  ou [2];
  logic [1:0]  odest [2];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axis_dest_extract #(
    .AXIS_BYTES(2), .AXIS_USER_BITS(2), .NUM_DESTS(3), .DEST_BYTE(1),
    .DEFAULT_DEST(0), .DROP_HEADER(1'b0)
  ) u_dut0 (
    .clk(clk), .aresetn(aresetn),
    .axis_i_tready(ir[0]), .axis_i_tvalid(iv[0]), .axis_i_tlast(il[0]),
    .axis_i_tdata(id[0]), .axis_i_tuser(iu[0]),
    .axis_o_tready(ordy[0]), .axis_o_tvalid(ov[0]), .axis_o_tlast(ol[0]),
    .axis_o_tdata(od[0]), .axis_o_tuser(ou[0]), .axis_o_tdest(odest[0]),
    .bad_dest(bad[0])
  );

  axis_dest_extract #(
    .AXIS_BYTES(2), .AXIS_USER_BITS(2), .NUM_DESTS(4), .DEST_BYTE(0),
    .DEFAULT_DEST(2), .DROP_HEADER(1'b1)
  ) u_dut1 (
    .clk(clk), .aresetn(aresetn),
    .axis_i_tready(ir[1]), .axis_i_tvalid(iv[1]), .axis_i_tlast(il[1]),
    .axis_i_tdata(id[1]), .axis_i_tuser(iu[1]),
    .axis_o_tready(ordy[1]), .axis_o_tvalid(ov[1]), .axis_o_tlast(ol[1]),
    .axis_o_tdata(od[1]), .axis_o_tuser(ou[1]), .axis_o_tdest(odest[1]),
    .bad_dest(bad[1])
  );

  function automatic int ndest(input int d); return (d == 0) ? 3 : 4; endfunction
  function automatic int defd(input int d);  return (d == 0) ? 0 : 2; endfunction
  function automatic bit drop(input int d);  return (d == 1);         endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s dut%0d: got %0h want %0h", name, d, act, req);
  endtask

  // ---------------- packet-level reference model ----------------
  beat_t      exp_q [2][$];
  beat_t      got_q [2][$];
  bit         hdr_m [2] = '{1'b1, 1'b1};
  logic [1:0] cur_m [2] = '{2'd0, 2'd0};
  bit         rdy_m [2] = '{1'b0, 1'b0};
  bit         bad_m [2] = '{1'b0, 1'b0};
  int         acc_cnt [2] = '{0, 0};
  int         bad_cnt [2] = '{0, 0};
  bit         mon_en = 1'b0;

  always @(negedge clk) begin
    beat_t      act;
    logic [7:0] raw;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (!aresetn) begin
          exp_q[d].delete();
          hdr_m[d] = 1'b1;
          rdy_m[d] = 1'b0;
          bad_m[d] = 1'b0;
        end
        chk("tready", d, 32'(ir[d]), 32'(rdy_m[d]));
        chk("tvalid", d, 32'(ov[d]), 32'(exp_q[d].size() > 0));
        chk("bad_dest", d, 32'(bad[d]), 32'(bad_m[d]));
        if (bad[d]) bad_cnt[d]++;
        act = {od[d], ou[d], ol[d], odest[d]};
        if (ov[d] && exp_q[d].size() > 0) chk("beat", d, 32'(act), 32'(exp_q[d][0]));
        // Predict the coming rising edge: transfers out, then accepts in.
        if (ov[d] && ordy[d]) begin
          got_q[d].push_back(act);
          if (exp_q[d].size() > 0) void'(exp_q[d].pop_front());
        end
        bad_m[d] = 1'b0;
        if (iv[d] && ir[d]) begin
          acc_cnt[d]++;
          if (hdr_m[d]) begin
            raw = (d == 0) ? id[d][15:8] : id[d][7:0];
            if (int'(raw) >= ndest(d)) begin
              cur_m[d] = 2'(defd(d));
              bad_m[d] = 1'b1;
            end else begin
              cur_m[d] = raw[1:0];
            end
            if (!drop(d)) exp_q[d].push_back({id[d], iu[d], il[d], cur_m[d]});
          end else begin
            exp_q[d].push_back({id[d], iu[d], il[d], cur_m[d]});
          end
          hdr_m[d] = il[d];
        end
        rdy_m[d] = aresetn && (exp_q[d].size() < 2);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input logic [15:0] data, input logic [1:0] user, input logic last);
    int n;
    n = 0;
    iv[d] = 1'b1; id[d] = data; iu[d] = user; il[d] = last;
    @(negedge clk);
    while (!ir[d] && n < 300) begin n++; @(negedge clk); end
    if (!ir[d]) chk("send_timeout", d, 32'(n), 32'd0);
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && n < 300) begin
      @(posedge clk); n++;
    end
    chk("drain", 0, 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rand_stream(input int d, input int nbeats);
    int          sent, len, r;
    logic [15:0] data;
    logic [7:0]  hb;
    sent = 0;
    while (sent < nbeats) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        data = 16'($urandom);
        if (k == 0) begin
          r  = $urandom_range(0, 9);
          hb = (r < 8) ? 8'(r) : 8'h41;
          if (d == 0) data[15:8] = hb; else data[7:0] = hb;
        end
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        send(d, data, 2'($urandom), (k == len - 1));
        sent++;
      end
    end
  endtask

  vec_t        tbl [$];
  beat_t       g;
  logic [15:0] stall_data [5];
  int          acc0;
  bit          done0, done1;

  initial begin
    tbl.push_back('{0, 16'h0211, 2'd1, 1'b0, 1'b1, 2'd2});
    tbl.push_back('{0, 16'h00AA, 2'd2, 1'b0, 1'b1, 2'd2});
    tbl.push_back('{0, 16'h00BB, 2'd3, 1'b1, 1'b1, 2'd2});
    tbl.push_back('{0, 16'h0133, 2'd0, 1'b0, 1'b1, 2'd1});
    tbl.push_back('{0, 16'h07CC, 2'd1, 1'b1, 1'b1, 2'd1});
    tbl.push_back('{0, 16'h0744, 2'd2, 1'b0, 1'b1, 2'd0});
    tbl.push_back('{0, 16'h00DD, 2'd3, 1'b1, 1'b1, 2'd0});
    tbl.push_back('{0, 16'h0355, 2'd0, 1'b1, 1'b1, 2'd0});
    tbl.push_back('{0, 16'h0266, 2'd1, 1'b1, 1'b1, 2'd2});
    tbl.push_back('{1, 16'h0003, 2'd0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1, 16'h0011, 2'd1, 1'b0, 1'b1, 2'd3});
    tbl.push_back('{1, 16'h0022, 2'd2, 1'b1, 1'b1, 2'd3});
    tbl.push_back('{1, 16'h0001, 2'd3, 1'b1, 1'b0, 2'd1});
    tbl.push_back('{1, 16'h0041, 2'd0, 1'b0, 1'b0, 2'd2});
    tbl.push_back('{1, 16'h0044, 2'd1, 1'b1, 1'b1, 2'd2});
    stall_data = '{16'h0150, 16'h0051, 16'h0052, 16'h0053, 16'h0054};

    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; il[d] = 1'b0; id[d] = 16'h0; iu[d] = 2'd0; ordy[d] = 1'b1;
    end

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_tready", d, 32'(ir[d]), 32'd0);
      chk("rst_tvalid", d, 32'(ov[d]), 32'd0);
      chk("rst_bad", d, 32'(bad[d]), 32'd0);
      chk("rst_payload", d, 32'({od[d], ou[d], ol[d], odest[d]}), 32'd0);
    end
    mon_en = 1'b1;
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 0, 32'(ir[0]), 32'd1);
    chk("ready_after_rst", 1, 32'(ir[1]), 32'd1);

    // ---- table: dest tagging, out-of-range, header drop ----
    foreach (tbl[i]) send(tbl[i].d, tbl[i].data, tbl[i].user, tbl[i].last);
    drain();
    for (int d = 0; d < 2; d++) begin
      foreach (tbl[i]) begin
        if (tbl[i].d == d && tbl[i].out) begin
          if (got_q[d].size() == 0) begin
            chk("tbl_missing", d, 32'(tbl[i].data), 32'hFFFF_FFFF);
          end else begin
            g = got_q[d].pop_front();
            chk("tbl_data", d, 32'(g.data), 32'(tbl[i].data));
            chk("tbl_user", d, 32'(g.user), 32'(tbl[i].user));
            chk("tbl_last", d, 32'(g.last), 32'(tbl[i].last));
            chk("tbl_dest", d, 32'(g.dest), 32'(tbl[i].dest));
          end
        end
      end
      chk("tbl_extra", d, 32'(got_q[d].size()), 32'd0);
    end
    chk("bad_pulses", 0, 32'(bad_cnt[0]), 32'd2);
    chk("bad_pulses", 1, 32'(bad_cnt[1]), 32'd1);

    // ---- backpressure: five beats offered into a stalled output ----
    got_q[0].delete();
    acc0 = acc_cnt[0];
    ordy[0] = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) send(0, stall_data[k], 2'(k), (k == 4));
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("stall_accepted", 0, 32'(acc_cnt[0] - acc0), 32'd2);
        chk("stall_tready", 0, 32'(ir[0]), 32'd0);
        chk("stall_tvalid", 0, 32'(ov[0]), 32'd1);
        chk("stall_head", 0, 32'(od[0]), 32'h0150);
        ordy[0] = 1'b1;
      end
    join
    drain();
    chk("stall_count", 0, 32'(got_q[0].size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (got_q[0].size() > 0) begin
        g = got_q[0].pop_front();
        chk("stall_order", 0, 32'(g.data), 32'(stall_data[k]));
        chk("stall_dest", 0, 32'(g.dest), 32'd1);
      end
    end

    // ---- asynchronous reset mid-packet ----
    send(0, 16'h0200, 2'd0, 1'b0);
    send(0, 16'h0081, 2'd1, 1'b0);
    #1 aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", 0, 32'(ov[0]), 32'd0);
    chk("midrst_tready", 0, 32'(ir[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2 aresetn = 1'b1;
    @(posedge clk); #1;
    got_q[0].delete();
    send(0, 16'h0100, 2'd2, 1'b0);
    send(0, 16'h00EE, 2'd3, 1'b1);
    drain();
    chk("midrst_count", 0, 32'(got_q[0].size()), 32'd2);
    while (got_q[0].size() > 0) begin
      g = got_q[0].pop_front();
      chk("midrst_dest", 0, 32'(g.dest), 32'd1);
    end

    // ---- random traffic on both instances ----
    done0 = 1'b0; done1 = 1'b0;
    fork
      begin rand_stream(0, 5000); done0 = 1'b1; end
      begin rand_stream(1, 5000); done1 = 1'b1; end
      begin
        while (!(done0 && done1)) begin
          @(posedge clk); #1;
          ordy[0] = ($urandom_range(0, 3) != 0);
          ordy[1] = ($urandom_range(0, 2) != 0);
        end
      end
    join
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
